// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single-port data_ram. It runs a three-state access FSM
// (IDLE/ACCESS/RESP) and arbitrates either round-robin or with fixed priority to m0.
//
// state  | meaning
// IDLE   | arbitrate; on grant latch request fields
// ACCESS | ram_ce high, drive latched fields; reads captured on closing edge
// RESP   | one-cycle ack to the granted master
module data_ram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W/8-1:0]   m0_sel,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W/8-1:0]   m1_sel,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  stallreq,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_sel,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                r_state;
    logic                  r_gnt;
    logic                  r_last;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_sel;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_m0_ack;
    logic                  r_m1_ack;
    logic [DATA_W-1:0]     r_m0_rdata;
    logic [DATA_W-1:0]     r_m1_rdata;

    logic                  w_any;
    logic                  w_pick_m1;
    logic                  w_access;

    // m1 wins only when alone, or on a tie when round-robin says m0 went last
    assign w_any     = m0_req | m1_req;
    assign w_pick_m1 = m1_req & (~m0_req | ((FIXED_PRIO == 1'b0) & ~r_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_sel      <= '0;
            r_wdata    <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick_m1;
                        r_last  <= w_pick_m1;
                        r_we    <= w_pick_m1 ? m1_we    : m0_we;
                        r_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
                        r_sel   <= w_pick_m1 ? m1_sel   : m0_sel;
                        r_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        if (r_gnt) r_m1_rdata <= ram_rdata;
                        else       r_m0_rdata <= ram_rdata;
                    end
                    r_m0_ack <= ~r_gnt;
                    r_m1_ack <= r_gnt;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ram port decoded from state and latched fields only, so no master input reaches it
    assign w_access  = (r_state == ACCESS);
    assign ram_ce    = w_access;
    assign ram_we    = w_access & r_we;
    assign ram_addr  = w_access ? r_addr  : '0;
    assign ram_sel   = w_access ? r_sel   : '0;
    assign ram_wdata = w_access ? r_wdata : '0;

    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign stallreq  = m0_req & ~r_m0_ack;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: a round-robin instance (dut 0) and a fixed-priority
// instance (dut 1), each with its own behavioural data_ram and a shared expected-ack queue.
module tb_data_ram_arbiter;

    typedef struct packed {
        logic [1:0]  m;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;

    // master index m: dut = m/2, port = m%2
    logic [3:0]        m_req;
    logic [3:0]        m_we;
    logic [3:0][31:0]  m_addr;
    logic [3:0][3:0]   m_sel;
    logic [3:0][31:0]  m_wdata;
    logic [3:0]        m_ack;
    logic [3:0][31:0]  m_rdata;
    logic [1:0]        stall;
    logic [1:0]        ram_ce;
    logic [1:0]        ram_we;
    logic [1:0][31:0]  ram_addr;
    logic [1:0][3:0]   ram_sel;
    logic [1:0][31:0]  ram_wdata;
    logic [1:0][31:0]  ram_rdata;

    logic [31:0] mem     [2][256];
    logic [31:0] ref_mem [2][256];

    exp_t exp_q[$];
    int   ack_log[$];
    int   ack_cyc[$];
    int   cyc;
    int   n_chk;
    int   n_err;
    logic saw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_ram_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .FIXED_PRIO(g == 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (m_req[2*g]),
            .m0_we     (m_we[2*g]),
            .m0_addr   (m_addr[2*g]),
            .m0_sel    (m_sel[2*g]),
            .m0_wdata  (m_wdata[2*g]),
            .m0_ack    (m_ack[2*g]),
            .m0_rdata  (m_rdata[2*g]),
            .m1_req    (m_req[2*g+1]),
            .m1_we     (m_we[2*g+1]),
            .m1_addr   (m_addr[2*g+1]),
            .m1_sel    (m_sel[2*g+1]),
            .m1_wdata  (m_wdata[2*g+1]),
            .m1_ack    (m_ack[2*g+1]),
            .m1_rdata  (m_rdata[2*g+1]),
            .stallreq  (stall[g]),
            .ram_ce    (ram_ce[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_sel   (ram_sel[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );
        assign ram_rdata[g] = mem[g][ram_addr[g][9:2]];
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (ram_ce[d] && ram_we[d])
                for (int b = 0; b < 4; b++)
                    if (ram_sel[d][b]) mem[d][ram_addr[d][9:2]][8*b +: 8] <= ram_wdata[d][8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // every ack must match the oldest outstanding request of that master
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (m_ack[m]) begin
                int idx;
                idx = -1;
                ack_log.push_back(m);
                ack_cyc.push_back(cyc);
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].m == 2'(m)) idx = i;
                if (idx < 0) begin
                    check($sformatf("ack_unexpected_m%0d", m), 32'd1, 32'd0);
                end else begin
                    if (exp_q[idx].rd) check($sformatf("rdata_m%0d", m), m_rdata[m], exp_q[idx].data);
                    exp_q.delete(idx);
                end
            end
        end
    end

    task automatic preload(input int d, input logic [31:0] addr, input logic [31:0] data);
        mem[d][addr[9:2]]     = data;
        ref_mem[d][addr[9:2]] = data;
    endtask

    // caller starts #1 after a rising edge; returns #1 after the edge ending the ack cycle
    task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wd, input bit keep);
        int   d;
        int   n;
        exp_t e;
        d      = m / 2;
        e.m    = 2'(m);
        e.rd   = ~we;
        e.data = ref_mem[d][addr[9:2]];
        if (we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[d][addr[9:2]][8*b +: 8] = wd[8*b +: 8];
        exp_q.push_back(e);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = addr;
        m_sel[m]   = sel;
        m_wdata[m] = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ack[m] && n < 40);
        check($sformatf("ack_seen_m%0d", m), 32'(m_ack[m]), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) m_req[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b0;
        m_req = '0; m_we = '0; m_addr = '0; m_sel = '0; m_wdata = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) begin
                mem[d][i]     = 32'h0;
                ref_mem[d][i] = 32'h0;
            end
        preload(0, 32'h10, 32'hDEADBEEF);
        preload(0, 32'h20, 32'hA5A5A5A5);
        preload(0, 32'h40, 32'h40404040);
        preload(0, 32'h44, 32'h44444444);
        preload(0, 32'h50, 32'h50505050);
        preload(0, 32'h54, 32'h54545454);
        preload(0, 32'h60, 32'h0BADF00D);
        preload(0, 32'h70, 32'h70707070);
        preload(0, 32'h74, 32'h74747474);
        preload(1, 32'h40, 32'h14000040);
        preload(1, 32'h44, 32'h14000044);
        preload(1, 32'h48, 32'h14000048);
        preload(1, 32'h50, 32'h15000050);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        check("rst_ram_addr", ram_addr[0], 32'd0);
        check("rst_acks", 32'(m_ack), 32'd0);
        check("rst_rdata", m_rdata[0], 32'd0);
        check("rst_stall_low", 32'(stall[0]), 32'd0);
        m_req[0] = 1'b1;
        #1;
        check("rst_stall_follows_req", 32'(stall[0]), 32'd1);
        m_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // m0 read with cycle-exact timing
        exp_q.push_back('{m: 2'd0, rd: 1'b1, data: 32'hDEADBEEF});
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h10; m_sel[0] = 4'hF;
        @(negedge clk);
        check("t1_c0_stall", 32'(stall[0]), 32'd1);
        check("t1_c0_ce", 32'(ram_ce[0]), 32'd0);
        @(negedge clk);
        check("t1_c1_ce", 32'(ram_ce[0]), 32'd1);
        check("t1_c1_addr", ram_addr[0], 32'h10);
        check("t1_c1_we", 32'(ram_we[0]), 32'd0);
        check("t1_c1_stall", 32'(stall[0]), 32'd1);
        @(negedge clk);
        check("t1_c2_ack", 32'(m_ack[0]), 32'd1);
        check("t1_c2_rdata", m_rdata[0], 32'hDEADBEEF);
        check("t1_c2_stall", 32'(stall[0]), 32'd0);
        check("t1_c2_ce", 32'(ram_ce[0]), 32'd0);
        @(posedge clk);
        #1;
        m_req[0] = 1'b0;

        // m1 byte-lane write, sel=0 write, read back
        do_access(1, 1'b1, 32'h20, 4'b0010, 32'h11223344, 1'b0);
        check("t2_rdata_kept_on_write", m_rdata[1], 32'h0);
        do_access(1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0);
        do_access(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        check("t2_read_merge", m_rdata[1], 32'hA5A533A5);

        // round-robin alternation on dut 0
        ack_log.delete();
        ack_cyc.delete();
        fork
            begin
                do_access(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);
                do_access(0, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0);
            end
            begin
                do_access(1, 1'b0, 32'h50, 4'hF, 32'h0, 1'b1);
                do_access(1, 1'b0, 32'h54, 4'hF, 32'h0, 1'b0);
            end
        join
        check("t3_nacks", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check($sformatf("t3_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));
        for (int i = 1; i < 4 && i < ack_cyc.size(); i++)
            check($sformatf("t3_gap_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

        // fixed priority on dut 1: m0 re-requests back to back
        ack_log.delete();
        ack_cyc.delete();
        fork
            begin
                do_access(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);
                do_access(2, 1'b0, 32'h44, 4'hF, 32'h0, 1'b1);
                do_access(2, 1'b0, 32'h48, 4'hF, 32'h0, 1'b0);
            end
            do_access(3, 1'b0, 32'h50, 4'hF, 32'h0, 1'b0);
        join
        check("t4_nacks", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check($sformatf("t4_order_%0d", i), 32'(ack_log[i]), (i == 3) ? 32'd3 : 32'd2);

        // reset in the middle of an m1 write on dut 0
        do_access(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        saw = 1'b0;
        m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h60; m_sel[1] = 4'hF; m_wdata[1] = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        check("t5_ce_in_access", 32'(ram_ce[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_ce_drops_async", 32'(ram_ce[0]), 32'd0);
        m_req[1] = 1'b0;
        repeat (3) begin @(negedge clk); saw = saw | m_ack[1]; end
        rst = 1'b1;
        repeat (3) begin @(negedge clk); saw = saw | m_ack[1]; end
        check("t5_no_m1_ack", 32'(saw), 32'd0);
        check("t5_mem_unchanged", mem[0][8'h18], 32'h0BADF00D);
        @(posedge clk);
        #1;
        ack_log.delete();
        ack_cyc.delete();
        fork
            do_access(0, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0);
            do_access(1, 1'b0, 32'h54, 4'hF, 32'h0, 1'b0);
        join
        check("t5_first_after_reset", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'hFFFF_FFFF, 32'd0);

        // fields changed during ACCESS are ignored until the next grant
        exp_q.push_back('{m: 2'd0, rd: 1'b1, data: 32'h70707070});
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h70; m_sel[0] = 4'hF;
        @(posedge clk);
        #1;
        m_addr[0] = 32'h74; m_sel[0] = 4'h3;
        exp_q.push_back('{m: 2'd0, rd: 1'b1, data: 32'h74747474});
        @(negedge clk);
        check("t6_addr_latched", ram_addr[0], 32'h70);
        check("t6_sel_latched", 32'(ram_sel[0]), 32'hF);
        @(negedge clk);
        check("t6_first_ack", 32'(m_ack[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("t6_next_addr", ram_addr[0], 32'h74);
        check("t6_next_sel", 32'(ram_sel[0]), 32'h3);
        @(negedge clk);
        check("t6_second_ack", 32'(m_ack[0]), 32'd1);
        @(posedge clk);
        #1;
        m_req[0] = 1'b0;
        repeat (3) @(negedge clk);

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
